// File: rtl/dsp_seq_pkg.sv
// Shared definitions for the DSP48A1 multiply-accumulate sequencer.
//   - seq_state_e : sequencer FSM states
//   - OPM_*       : OPMODE words driven to the slice
//   - TAG_*       : bit positions inside a pipeline tag {vld, first, last}
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } seq_state_e;

  // X=0/Z=0 while idle, X=M/Z=0 loads the first product, X=M/Z=P accumulates.
  localparam logic [7:0] OPM_IDLE = 8'h00;
  localparam logic [7:0] OPM_LOAD = 8'h01;
  localparam logic [7:0] OPM_MAC  = 8'h09;

  localparam int unsigned TAG_W     = 3;
  localparam int unsigned TAG_LAST  = 0;
  localparam int unsigned TAG_FIRST = 1;
  localparam int unsigned TAG_VLD   = 2;

  typedef logic [TAG_W-1:0] tag_t;

  function automatic tag_t make_tag(input logic vld, input logic first, input logic last);
    tag_t t;
    t            = '0;
    t[TAG_VLD]   = vld;
    t[TAG_FIRST] = first;
    t[TAG_LAST]  = last;
    return t;
  endfunction

endpackage

// File: rtl/dsp_seq_tag_pipe.sv
// Tag shift register that shadows the DSP48A1 pipeline.
// Stage 0 is loaded on the same edge that registers the operand pair, so stage d holds the tag
// of the pair that was on the slice A/B inputs d cycles earlier.
// Ports:
//   i_clk       clock
//   i_clr       synchronous clear of every stage (reset or job flush)
//   i_tag       tag of the pair being transferred this cycle (zero on no transfer)
//   o_opm_load  pair at the OPMODE tap is the first pair of its job
//   o_p_vld     a real pair sits at the P tap
//   o_p_last    the pair at the P tap is the last one of its job
module dsp_seq_tag_pipe
  import dsp_seq_pkg::*;
#(
  parameter int unsigned OPM_TAP = 1,
  parameter int unsigned P_TAP   = 3
) (
  input  logic i_clk,
  input  logic i_clr,
  input  tag_t i_tag,
  output logic o_opm_load,
  output logic o_p_vld,
  output logic o_p_last
);

  localparam int unsigned DEPTH = P_TAP + 1;

  tag_t r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_opm_load = r_stage[OPM_TAP][TAG_VLD] & r_stage[OPM_TAP][TAG_FIRST];
  assign o_p_vld    = r_stage[P_TAP][TAG_VLD];
  assign o_p_last   = r_stage[P_TAP][TAG_LAST];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1 slice (A1REG=B1REG=MREG=PREG=OPMODEREG=1) as an unsigned MAC engine that
// returns sum(a[i]*b[i]) over len operand pairs, modulo 2^48, with a carry-out overflow flag.
// Build option: define DSP_SEQ_SAT_OUT_EN to saturate res_data to all ones when res_ovf is set;
// otherwise res_data is the raw wrapped P value.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_start, i_len               start a job of i_len pairs (sampled only in IDLE)
//   i_abort                      flush the running job, no result (ignored in IDLE)
//   i_in_valid/o_in_ready        operand pair handshake, pair on i_in_a/i_in_b
//   o_dsp_a/o_dsp_b/o_dsp_opmode slice A, B, OPMODE inputs
//   i_dsp_p, i_dsp_carryout      slice P and CARRYOUT outputs
//   o_res_valid/i_res_ready      result handshake, result on o_res_data/o_res_ovf
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned OPM_DLY = 1,
  parameter int unsigned P_DLY   = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_abort,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [17:0]      i_in_a,
  input  logic [17:0]      i_in_b,
  output logic [17:0]      o_dsp_a,
  output logic [17:0]      o_dsp_b,
  output logic [7:0]       o_dsp_opmode,
  input  logic [47:0]      i_dsp_p,
  input  logic             i_dsp_carryout,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [47:0]      o_res_data,
  output logic             o_res_ovf
);

  seq_state_e       r_state;
  seq_state_e       w_state_next;
  logic [LEN_W-1:0] r_remain;
  logic             r_first;
  logic [17:0]      r_a;
  logic [17:0]      r_b;
  logic             r_ovf;
  logic [47:0]      r_res_data;

  logic             w_abort;
  logic             w_clr;
  logic             w_xfer;
  logic             w_last_xfer;
  logic             w_capture;
  logic             w_ovf_now;
  logic             w_opm_load;
  logic             w_p_vld;
  logic             w_p_last;
  tag_t             w_tag_in;
  logic [47:0]      w_res_capture;

  // Abort only means something once a job is in flight; rst still wins over it.
  assign w_abort     = i_abort && (r_state != StIdle);
  assign w_clr       = i_rst | w_abort;
  assign w_xfer      = (r_state == StRun) && i_in_valid && !i_abort;
  assign w_last_xfer = w_xfer && (r_remain == LEN_W'(1));
  assign w_tag_in    = make_tag(w_xfer, w_xfer & r_first, w_last_xfer);
  assign w_capture   = (r_state == StDrain) && w_p_vld && w_p_last && !i_abort;
  // Include the carry of the capture cycle itself, which r_ovf has not seen yet.
  assign w_ovf_now   = r_ovf | (w_p_vld & i_dsp_carryout);

`ifdef DSP_SEQ_SAT_OUT_EN
  assign w_res_capture = w_ovf_now ? 48'hFFFF_FFFF_FFFF : i_dsp_p;
`else
  assign w_res_capture = i_dsp_p;
`endif

  dsp_seq_tag_pipe #(
    .OPM_TAP (OPM_DLY),
    .P_TAP   (P_DLY)
  ) u_tag_pipe (
    .i_clk      (i_clk),
    .i_clr      (w_clr),
    .i_tag      (w_tag_in),
    .o_opm_load (w_opm_load),
    .o_p_vld    (w_p_vld),
    .o_p_last   (w_p_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_in_ready   = 1'b0;
    o_res_valid  = 1'b0;
    o_dsp_opmode = OPM_IDLE;
    o_res_data   = '0;
    o_res_ovf    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next = (i_len != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        o_in_ready   = 1'b1;
        // Bubbles also get MAC so they add a zero product and keep P intact.
        o_dsp_opmode = w_opm_load ? OPM_LOAD : OPM_MAC;
        if (i_abort) begin
          w_state_next = StIdle;
        end else if (w_last_xfer) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        o_dsp_opmode = w_opm_load ? OPM_LOAD : OPM_MAC;
        if (i_abort) begin
          w_state_next = StIdle;
        end else if (w_capture) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        o_res_valid = 1'b1;
        o_res_data  = r_res_data;
        o_res_ovf   = r_ovf;
        if (i_abort || i_res_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_remain   <= '0;
      r_first    <= 1'b0;
      r_ovf      <= 1'b0;
      r_res_data <= '0;
    end else begin
      // Non-transfer cycles present a zero product to the slice.
      r_a <= w_xfer ? i_in_a : '0;
      r_b <= w_xfer ? i_in_b : '0;
      if ((r_state == StIdle) && i_start) begin
        r_remain   <= i_len;
        r_first    <= 1'b1;
        r_ovf      <= 1'b0;
        r_res_data <= '0;
      end else if (w_abort) begin
        r_remain   <= '0;
        r_first    <= 1'b0;
        r_ovf      <= 1'b0;
        r_res_data <= '0;
      end else begin
        if (w_xfer) begin
          r_remain <= r_remain - LEN_W'(1);
          r_first  <= 1'b0;
        end
        if (w_capture) begin
          r_res_data <= w_res_capture;
          r_ovf      <= w_ovf_now;
        end else if (w_p_vld && i_dsp_carryout) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign o_dsp_a = r_a;
  assign o_dsp_b = r_b;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural DSP48A1 slice (A1REG=B1REG=MREG=PREG=
// OPMODEREG=1, CARRYOUT registered alongside P). Expected results are queued when a job is
// started and popped when res_valid appears. Honours DSP_SEQ_SAT_OUT_EN for the overflow case.
module tb_dsp_mac_sequencer;

  localparam int unsigned LEN_W = 16;
  localparam int unsigned P_DLY = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [17:0]      in_a;
  logic [17:0]      in_b;
  logic [17:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [7:0]       dsp_opmode;
  logic [47:0]      dsp_p;
  logic             dsp_carryout;
  logic             res_valid;
  logic             res_ready;
  logic [47:0]      res_data;
  logic             res_ovf;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(
    .LEN_W   (LEN_W),
    .OPM_DLY (1),
    .P_DLY   (P_DLY)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_len          (len),
    .i_abort        (abort),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_a         (in_a),
    .i_in_b         (in_b),
    .o_dsp_a        (dsp_a),
    .o_dsp_b        (dsp_b),
    .o_dsp_opmode   (dsp_opmode),
    .i_dsp_p        (dsp_p),
    .i_dsp_carryout (dsp_carryout),
    .o_res_valid    (res_valid),
    .i_res_ready    (res_ready),
    .o_res_data     (res_data),
    .o_res_ovf      (res_ovf)
  );

  // Behavioural slice: A1/B1 -> M -> P, OPMODE registered once.
  logic [17:0] s_a1, s_b1;
  logic [35:0] s_m;
  logic [7:0]  s_opm;
  logic [47:0] s_p;
  logic        s_co;
  logic [47:0] s_x, s_z;
  logic [48:0] s_sum;

  always_comb begin
    s_x   = (s_opm[1:0] == 2'b01) ? {12'b0, s_m} : 48'b0;
    s_z   = (s_opm[3:2] == 2'b10) ? s_p : 48'b0;
    s_sum = {1'b0, s_z} + {1'b0, s_x};
  end

  always @(posedge clk) begin
    if (rst) begin
      s_a1 <= '0; s_b1 <= '0; s_m <= '0; s_opm <= '0; s_p <= '0; s_co <= 1'b0;
    end else begin
      s_a1  <= dsp_a;
      s_b1  <= dsp_b;
      s_m   <= {18'b0, s_a1} * {18'b0, s_b1};
      s_opm <= dsp_opmode;
      s_p   <= s_sum[47:0];
      s_co  <= s_sum[48];
    end
  end

  assign dsp_p        = s_p;
  assign dsp_carryout = s_co;

  int cyc = 0;
  int load_seen = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dsp_opmode == 8'h01) load_seen <= load_seen + 1;
  end

  typedef struct packed {
    logic [47:0] data;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [LEN_W-1:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_pair(input logic [17:0] a, input logic [17:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  // Waits (bounded) for res_valid; reports whether it came and at which cycle.
  task automatic collect(input int budget, output bit got, output int when);
    got  = 1'b0;
    when = 0;
    for (int i = 0; i < budget; i++) begin
      if (res_valid === 1'b1) begin
        got  = 1'b1;
        when = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++; if (dsp_opmode !== 8'h00) begin errors++; $display("FAIL reset_opmode got %h want 00", dsp_opmode); end
    checks++; if ({dsp_a, dsp_b} !== 36'h0) begin errors++; $display("FAIL reset_ab got %h/%h want 0/0", dsp_a, dsp_b); end
    checks++; if ({res_data, res_ovf} !== 49'h0) begin errors++; $display("FAIL reset_res got %h/%b want 0/0", res_data, res_ovf); end
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready got %b want 0", in_ready); end
  endtask

  task automatic test_back_to_back();
    int   l0, t_last, when;
    bit   got;
    exp_t e;
    l0 = load_seen;
    sb.push_back('{data: 48'd100, ovf: 1'b0});
    start_job(16'd4);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_a     = 18'(2 * i + 1);
      in_b     = 18'(2 * i + 2);
      tick();
      if (i == 0) begin
        checks++;
        if ({dsp_a, dsp_b} !== {18'd1, 18'd2}) begin
          errors++; $display("FAIL b2b_operands got %0d/%0d want 1/2", dsp_a, dsp_b);
        end
      end
    end
    in_valid = 1'b0;
    t_last   = cyc;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_drain_ready got %b want 0", in_ready); end
    collect(20, got, when);
    checks++;
    if (!got) begin
      errors++; $display("FAIL b2b_timeout got no res_valid want res_valid");
    end else begin
      e = sb.pop_front();
      checks++; if (when - t_last != P_DLY + 1) begin errors++; $display("FAIL b2b_latency got %0d want %0d", when - t_last, P_DLY + 1); end
      checks++; if (res_data !== e.data) begin errors++; $display("FAIL b2b_data got %0d want %0d", res_data, e.data); end
      checks++; if (res_ovf !== e.ovf) begin errors++; $display("FAIL b2b_ovf got %b want %b", res_ovf, e.ovf); end
      checks++; if (dsp_opmode !== 8'h00) begin errors++; $display("FAIL b2b_done_opmode got %h want 00", dsp_opmode); end
      handshake();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL b2b_release got %b want 0", res_valid); end
    end
    checks++; if (load_seen - l0 != 1) begin errors++; $display("FAIL b2b_loads got %0d want 1", load_seen - l0); end
  endtask

  task automatic test_gapped();
    int   l0, when;
    bit   got;
    exp_t e;
    logic [17:0] av [3];
    logic [17:0] bv [3];
    av = '{18'd2, 18'd4, 18'd6};
    bv = '{18'd3, 18'd5, 18'd7};
    l0 = load_seen;
    sb.push_back('{data: 48'd68, ovf: 1'b0});
    start_job(16'd3);
    for (int i = 0; i < 3; i++) begin
      send_pair(av[i], bv[i]);
      if (i < 2) repeat (2) tick();
    end
    collect(20, got, when);
    checks++;
    if (!got) begin
      errors++; $display("FAIL gap_timeout got no res_valid want res_valid");
    end else begin
      e = sb.pop_front();
      checks++; if (res_data !== e.data) begin errors++; $display("FAIL gap_data got %0d want %0d", res_data, e.data); end
      checks++; if (res_ovf !== e.ovf) begin errors++; $display("FAIL gap_ovf got %b want %b", res_ovf, e.ovf); end
      handshake();
    end
    checks++; if (load_seen - l0 != 1) begin errors++; $display("FAIL gap_loads got %0d want 1", load_seen - l0); end
  endtask

  task automatic test_two_jobs();
    int   when;
    bit   got;
    exp_t e;
    sb.push_back('{data: 48'd10025, ovf: 1'b0});
    sb.push_back('{data: 48'd101, ovf: 1'b0});
    for (int j = 0; j < 2; j++) begin
      start_job(16'd2);
      if (j == 0) begin
        send_pair(18'd100, 18'd100);
        send_pair(18'd5, 18'd5);
      end else begin
        send_pair(18'd10, 18'd10);
        send_pair(18'd1, 18'd1);
      end
      collect(20, got, when);
      checks++;
      if (!got) begin
        errors++; $display("FAIL two_timeout job %0d got no res_valid want res_valid", j);
      end else begin
        e = sb.pop_front();
        checks++; if (res_data !== e.data) begin errors++; $display("FAIL two_data job %0d got %0d want %0d", j, res_data, e.data); end
        handshake();
      end
    end
  endtask

  task automatic test_len_zero();
    exp_t e;
    sb.push_back('{data: 48'd0, ovf: 1'b0});
    start_job(16'd0);
    checks++;
    if (res_valid !== 1'b1) begin
      errors++; $display("FAIL zero_valid got %b want 1", res_valid);
    end else begin
      e = sb.pop_front();
      checks++; if ({res_data, res_ovf} !== {e.data, e.ovf}) begin errors++; $display("FAIL zero_res got %0d/%b want %0d/%b", res_data, res_ovf, e.data, e.ovf); end
      for (int i = 0; i < 5; i++) begin
        tick();
        checks++;
        if ({res_valid, res_data, res_ovf} !== {1'b1, e.data, e.ovf}) begin
          errors++; $display("FAIL zero_hold cycle %0d got %b/%0d/%b want 1/%0d/%b", i, res_valid, res_data, res_ovf, e.data, e.ovf);
        end
      end
      handshake();
      checks++; if ({res_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL zero_idle got %b%b want 00", res_valid, in_ready); end
    end
  endtask

  task automatic test_overflow();
    int          when;
    bit          got;
    exp_t        e;
    logic [47:0] prod;
    logic [48:0] acc;
    logic        ovf;
    prod = 48'h3FFFF * 48'h3FFFF;
    acc  = '0;
    ovf  = 1'b0;
    for (int i = 0; i < 4100; i++) begin
      acc = {1'b0, acc[47:0]} + {1'b0, prod};
      if (acc[48]) ovf = 1'b1;
    end
`ifdef DSP_SEQ_SAT_OUT_EN
    sb.push_back('{data: (ovf ? 48'hFFFF_FFFF_FFFF : acc[47:0]), ovf: ovf});
`else
    sb.push_back('{data: acc[47:0], ovf: ovf});
`endif
    start_job(16'd4100);
    in_valid = 1'b1;
    in_a     = 18'h3FFFF;
    in_b     = 18'h3FFFF;
    repeat (4100) tick();
    in_valid = 1'b0;
    collect(20, got, when);
    checks++;
    if (!got) begin
      errors++; $display("FAIL ovf_timeout got no res_valid want res_valid");
    end else begin
      e = sb.pop_front();
      checks++; if (res_ovf !== e.ovf) begin errors++; $display("FAIL ovf_flag got %b want %b", res_ovf, e.ovf); end
      checks++; if (res_data !== e.data) begin errors++; $display("FAIL ovf_data got %h want %h", res_data, e.data); end
      handshake();
    end
  endtask

  task automatic test_abort_rst();
    int   when, stray;
    bit   got;
    exp_t e;
    start_job(16'd5);
    send_pair(18'd9, 18'd9);
    send_pair(18'd8, 18'd8);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({in_ready, res_valid, dsp_opmode} !== 10'h0) begin errors++; $display("FAIL abort_idle got %b/%b/%h want 0/0/00", in_ready, res_valid, dsp_opmode); end
    stray = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (res_valid !== 1'b0) stray++; end
    checks++; if (stray != 0) begin errors++; $display("FAIL abort_result got %0d valid cycles want 0", stray); end

    start_job(16'd1);
    send_pair(18'd7, 18'd7);
    checks++; if ({in_ready, res_valid} !== 2'b00) begin errors++; $display("FAIL drain_state got %b%b want 00", in_ready, res_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (res_valid !== 1'b0) stray++; end
    checks++; if (stray != 0) begin errors++; $display("FAIL rst_result got %0d valid cycles want 0", stray); end

    // Abort alongside start in IDLE must be ignored.
    sb.push_back('{data: 48'd9, ovf: 1'b0});
    abort = 1'b1;
    start_job(16'd1);
    abort = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_abort got %b want 1", in_ready); end
    send_pair(18'd3, 18'd3);
    collect(20, got, when);
    checks++;
    if (!got) begin
      errors++; $display("FAIL post_abort_timeout got no res_valid want res_valid");
    end else begin
      e = sb.pop_front();
      checks++; if (res_data !== e.data) begin errors++; $display("FAIL post_abort_data got %0d want %0d", res_data, e.data); end
      handshake();
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_two_jobs();
    test_len_zero();
    test_overflow();
    test_abort_rst();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
